// File: rtl/alu_result_stage.sv
// alu_result_stage: flags capture and 2-entry skid buffer behind the ALU result mux, with a saturating delivered-result count.
// Define ALU_RES_PARITY_EN to carry an even-parity bit with each entry on out_par.
module alu_result_stage #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_sel,
    input  logic             in_carry,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_sel,
    output logic [3:0]       out_flags,
    output logic             out_par,
    output logic [CNT_W-1:0] res_count
);
    localparam int EW = WIDTH + 7;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t state, state_nx;
    logic [EW-1:0] head, skid, in_ent;
    logic acc, dlv, head_new, head_skid, skid_ld;
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign acc       = in_valid & in_ready;
    assign dlv       = out_valid & out_ready;
    // logic ops (sel[2]) carry no meaningful carry/overflow
    assign in_ent    = {in_data, in_sel, in_data[WIDTH-1], in_data == '0,
                        in_carry & ~in_sel[2], in_ovf & ~in_sel[2]};
    assign head_new  = acc & ((state == EMPTY) | dlv);
    assign head_skid = (state == FULL) & dlv;
    assign skid_ld   = acc & (state == ONE) & ~dlv;
    assign out_data  = head[EW-1:7];
    assign out_sel   = head[6:4];
    assign out_flags = head[3:0];
    always_comb begin
        state_nx = state;
        case (state)
            EMPTY:   state_nx = acc ? ONE : EMPTY;
            ONE:     state_nx = (acc & ~dlv) ? FULL : (~acc & dlv) ? EMPTY : ONE;
            FULL:    state_nx = dlv ? ONE : FULL;
            default: state_nx = EMPTY;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            head      <= '0;
            skid      <= '0;
            res_count <= '0;
        end else begin
            state <= state_nx;
            if (head_new) head <= in_ent;
            else if (head_skid) head <= skid;
            if (skid_ld) skid <= in_ent;
            if (dlv && res_count != '1) res_count <= res_count + CNT_W'(1);
        end
    end
`ifdef ALU_RES_PARITY_EN
    logic head_par, skid_par;
    assign out_par = head_par;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_par <= 1'b0;
            skid_par <= 1'b0;
        end else begin
            if (head_new) head_par <= ^in_data;
            else if (head_skid) head_par <= skid_par;
            if (skid_ld) skid_par <= ^in_data;
        end
    end
`else
    assign out_par = 1'b0;
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: randomized and directed checks of alu_result_stage against a queue-based reference model.
module tb_alu_result_stage;
    logic clk = 0, rst_n = 0;
    logic in_valid = 0, in_carry = 0, in_ovf = 0, out_ready = 0;
    logic [7:0] in_data = 0;
    logic [2:0] in_sel = 0;
    logic in_ready, out_valid, out_par, in_ready4, out_valid4, out_par4;
    logic [7:0] out_data, out_data4;
    logic [2:0] out_sel, out_sel4;
    logic [3:0] out_flags, out_flags4, res_count4;
    logic [15:0] res_count;
    int tests = 0, fails = 0;
    logic [14:0] q[$];
    logic [14:0] last = 0;
    int cnt = 0, cnt4 = 0;

    always #5 clk = ~clk;

    alu_result_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .in_carry(in_carry), .in_ovf(in_ovf),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sel(out_sel), .out_flags(out_flags), .out_par(out_par), .res_count(res_count));
    alu_result_stage #(.CNT_W(4)) sat4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_sel(in_sel), .in_carry(in_carry), .in_ovf(in_ovf),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .out_sel(out_sel4), .out_flags(out_flags4), .out_par(out_par4), .res_count(res_count4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_par(input logic [7:0] d);
`ifdef ALU_RES_PARITY_EN
        return ^d;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_all();
        logic [14:0] cur;
        cur = (q.size() != 0) ? q[0] : last;
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_data", out_data, cur[14:7]);
        chk("out_sel", out_sel, cur[6:4]);
        chk("out_flags", out_flags, cur[3:0]);
        chk("out_par", out_par, exp_par(cur[14:7]));
        chk("res_count", res_count, cnt);
        chk("res_count4", res_count4, cnt4);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic [2:0] s,
                        input logic c, input logic o, input logic r);
        logic acc, dlv;
        logic [3:0] f;
        in_valid = v; in_data = d; in_sel = s; in_carry = c; in_ovf = o; out_ready = r;
        acc = v && q.size() < 2;
        dlv = q.size() != 0 && r;
        f[3] = d[7];
        f[2] = (d == 0);
        f[1] = s[2] ? 1'b0 : c;
        f[0] = s[2] ? 1'b0 : o;
        @(posedge clk);
        if (dlv) begin
            last = q.pop_front();
            cnt = (cnt < 65535) ? cnt + 1 : cnt;
            cnt4 = (cnt4 < 15) ? cnt4 + 1 : cnt4;
        end
        if (acc) q.push_back({d, s, f});
        @(negedge clk);
        check_all();
    endtask

    task automatic reset_mid();
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_count", res_count, 0);
        q.delete(); last = 0; cnt = 0; cnt4 = 0;
        @(negedge clk);
        check_all();
        rst_n = 1;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_all();
        chk("rst_flags", out_flags, 0);
        rst_n = 1;
        step(1, 8'h80, 0, 1, 1, 1);
        chk("single_data", out_data, 8'h80);
        chk("single_flags", out_flags, 4'b1011);
        step(1, 8'h00, 3'b100, 1, 1, 1);
        chk("logic_flags", out_flags, 4'b0100);
        step(1, 8'h07, 3'b001, 0, 0, 1);
        chk("par_07", out_par, exp_par(8'h07));
        step(0, 0, 0, 0, 0, 1);
        step(1, 8'hA5, 0, 0, 0, 0);
        step(1, 8'h3C, 0, 0, 0, 0);
        chk("bp_ready", in_ready, 0);
        step(1, 8'hF0, 0, 0, 0, 0);
        chk("bp_head", out_data, 8'hA5);
        step(0, 0, 0, 0, 0, 1);
        chk("bp_drain2", out_data, 8'h3C);
        step(0, 0, 0, 0, 0, 1);
        chk("bp_empty", out_valid, 0);
        chk("bp_retain", out_data, 8'h3C);
        step(1, 8'h11, 0, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0, 0);
        reset_mid();
        for (int i = 0; i < 10; i++) begin
            step(1, 8'(i + 1), 3'(i), 1'(i), 1'(i >> 1), 1);
            chk("stream_ready", in_ready, 1);
        end
        step(0, 0, 0, 0, 0, 1);
        chk("stream_cnt", res_count, 10);
        for (int i = 0; i < 20; i++) step(1, 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1);
        chk("sat4", res_count4, 15);
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, 8'($urandom), 3'($urandom), 1'($urandom),
                 1'($urandom), ($urandom % 3) != 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
